// File: rtl/uart_ctrl_regs_if.sv
// Memory-mapped register bus between a CPU-side master and the UART control block.
// The master drives address/data/strobes; the slave returns read data and a one-cycle ready.
interface uart_ctrl_regs_if;
    logic [31:0] daddr_i;
    logic [31:0] dwdata_i;
    logic [3:0]  dstrb_i;
    logic        dwrite_i;
    logic        dvalid_i;
    logic [31:0] drdata_o;
    logic        dready_o;

    modport master (
        output daddr_i, dwdata_i, dstrb_i, dwrite_i, dvalid_i,
        input  drdata_o, dready_o
    );

    modport slave (
        input  daddr_i, dwdata_i, dstrb_i, dwrite_i, dvalid_i,
        output drdata_o, dready_o
    );
endinterface

// File: rtl/uart_ctrl_regs.sv
// UART control/status register block with TX and RX byte FIFOs behind a simple valid/ready bus.
// Define UART_IRQ_EN to build the IRQ_EN/IRQ_STAT registers and the irq_o interrupt output.
module uart_ctrl_regs #(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int          DEPTH        = 8,
    parameter logic [31:0] BAUD_DIV_RST = 32'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_ctrl_regs_if.slave     bus,
    input  logic                tx_rd_en_i,
    output logic [7:0]          tx_data_o,
    output logic                tx_empty_o,
    input  logic                rx_wr_en_i,
    input  logic [7:0]          rx_data_i,
    output logic                rx_full_o,
    output logic                tx_en_o,
    output logic                rx_en_o,
    output logic                parity_en_o,
    output logic                parity_odd_o,
    output logic [1:0]          data_bits_o,
    output logic [31:0]         baud_div_o,
    output logic                irq_o
);
    localparam int          LW  = $clog2(DEPTH) + 1;
    localparam int          PW  = $clog2(DEPTH);
    localparam logic [31:0] BAD = 32'hDEAD_DEAD;

    localparam logic [7:0] A_TXDATA   = 8'h00;
    localparam logic [7:0] A_RXDATA   = 8'h04;
    localparam logic [7:0] A_CTRL     = 8'h08;
    localparam logic [7:0] A_STATUS   = 8'h0C;
    localparam logic [7:0] A_BAUD     = 8'h10;
    localparam logic [7:0] A_IRQ_EN   = 8'h14;
    localparam logic [7:0] A_IRQ_STAT = 8'h18;
    localparam logic [7:0] A_WM       = 8'h1C;

    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_next;

    logic [5:0]  ctrl;
    logic [31:0] baud;
    logic [7:0]  tx_wm, rx_wm;
    logic        ovr;
    logic [31:0] rdata, rd_mux;

    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wp, tx_rp;
    logic [LW-1:0] tx_level;
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wp, rx_rp;
    logic [LW-1:0] rx_level;

    logic       hit, is_wr, stall, accept, wr_acc;
    logic [7:0] off, tx_mask;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_push, tx_pop, rx_push, rx_pop, ovr_set;
    logic       unused_bits;

    assign hit    = bus.dvalid_i && (bus.daddr_i[31:16] == BASE_ADDR[31:16]);
    assign off    = bus.daddr_i[7:0];
    assign is_wr  = bus.dwrite_i;
    assign wr_acc = accept && is_wr;
    assign unused_bits = ^{bus.dstrb_i, bus.daddr_i[15:8]};

    assign tx_full  = (tx_level == LW'(DEPTH));
    assign tx_empty = (tx_level == '0);
    assign rx_full  = (rx_level == LW'(DEPTH));
    assign rx_empty = (rx_level == '0);

    // Stall decisions use registered levels only, so a same-cycle UART pop never unblocks a write early.
    assign stall = (is_wr && off == A_TXDATA && tx_full) || (!is_wr && off == A_RXDATA && rx_empty);

    assign tx_push = wr_acc && off == A_TXDATA;
    assign tx_pop  = tx_rd_en_i && !tx_empty;
    assign rx_pop  = accept && !is_wr && off == A_RXDATA;
    assign rx_push = rx_wr_en_i && (!rx_full || rx_pop);
    assign ovr_set = rx_wr_en_i && rx_full && !rx_pop;
    assign tx_mask = 8'hFF >> (2'd3 - ctrl[5:4]);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (hit && !stall) begin
                accept     = 1'b1;
                state_next = ACK;
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage carries no reset; pointers and levels define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && tx_push) tx_mem[tx_wp] <= bus.dwdata_i[7:0] & tx_mask;
        if (rst_n && rx_push) rx_mem[rx_wp] <= rx_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wp <= '0; tx_rp <= '0; tx_level <= '0;
            rx_wp <= '0; rx_rp <= '0; rx_level <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + 1'b1;
                2'b01:   tx_level <= tx_level - 1'b1;
                default: tx_level <= tx_level;
            endcase
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + 1'b1;
                2'b01:   rx_level <= rx_level - 1'b1;
                default: rx_level <= rx_level;
            endcase
        end
    end

`ifdef UART_IRQ_EN
    logic [2:0] irq_en, irq_stat, irq_set, irq_clr;
    logic       irq_q;

    assign irq_set = {ovr_set && !ovr,
                      32'(rx_level) >= 32'(rx_wm),
                      32'(tx_level) <= 32'(tx_wm)};
    assign irq_clr = (wr_acc && off == A_IRQ_STAT) ? bus.dwdata_i[2:0] : 3'b000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_en   <= '0;
            irq_stat <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_acc && off == A_IRQ_EN) irq_en <= bus.dwdata_i[2:0];
            irq_stat <= (irq_stat & ~irq_clr) | irq_set;
            irq_q    <= |(irq_stat & irq_en);
        end
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rd_mux = BAD;
        case (off)
            A_RXDATA:   rd_mux = {24'h0, rx_mem[rx_rp]};
            A_CTRL:     rd_mux = {26'h0, ctrl};
            A_STATUS:   rd_mux = {8'h0, 8'(rx_level), 8'(tx_level), 3'b000,
                                  ovr, rx_empty, rx_full, tx_empty, tx_full};
            A_BAUD:     rd_mux = baud;
            A_WM:       rd_mux = {16'h0, rx_wm, tx_wm};
`ifdef UART_IRQ_EN
            A_IRQ_EN:   rd_mux = {29'h0, irq_en};
            A_IRQ_STAT: rd_mux = {29'h0, irq_stat};
`endif
            default:    rd_mux = BAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl  <= '0;
            baud  <= BAUD_DIV_RST;
            tx_wm <= '0;
            rx_wm <= '0;
            ovr   <= 1'b0;
            rdata <= '0;
        end else begin
            if (wr_acc) begin
                case (off)
                    A_CTRL: ctrl <= bus.dwdata_i[5:0];
                    A_BAUD: baud <= bus.dwdata_i;
                    A_WM: begin
                        rx_wm <= bus.dwdata_i[15:8];
                        tx_wm <= bus.dwdata_i[7:0];
                    end
                    default: ;
                endcase
            end
            // A new overrun in the same cycle as its W1C keeps the flag set.
            if (ovr_set)                                             ovr <= 1'b1;
            else if (wr_acc && off == A_STATUS && bus.dwdata_i[4])   ovr <= 1'b0;
            rdata <= (accept && !is_wr) ? rd_mux : 32'h0;
        end
    end

    assign bus.dready_o = (state == ACK);
    assign bus.drdata_o = rdata;
    assign tx_data_o    = tx_mem[tx_rp];
    assign tx_empty_o   = tx_empty;
    assign rx_full_o    = rx_full;
    assign tx_en_o      = ctrl[0];
    assign rx_en_o      = ctrl[1];
    assign parity_en_o  = ctrl[2];
    assign parity_odd_o = ctrl[3];
    assign data_bits_o  = ctrl[5:4];
    assign baud_div_o   = baud;
endmodule

// File: tb/tb_uart_ctrl_regs.sv
// Randomized self-checking bench for uart_ctrl_regs; FIFO contents and flags are tracked with queues.
module tb_uart_ctrl_regs;
    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BRST  = 32'h0000_1234;
    localparam logic [31:0] BAD   = 32'hDEAD_DEAD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_ctrl_regs_if bus ();
    logic        tx_rd_en, tx_empty, rx_wr_en, rx_full;
    logic [7:0]  tx_data, rx_data;
    logic        tx_en, rx_en, parity_en, parity_odd, irq;
    logic [1:0]  data_bits;
    logic [31:0] baud_div;

    uart_ctrl_regs #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .BAUD_DIV_RST(BRST)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .tx_rd_en_i(tx_rd_en), .tx_data_o(tx_data), .tx_empty_o(tx_empty),
        .rx_wr_en_i(rx_wr_en), .rx_data_i(rx_data), .rx_full_o(rx_full),
        .tx_en_o(tx_en), .rx_en_o(rx_en), .parity_en_o(parity_en), .parity_odd_o(parity_odd),
        .data_bits_o(data_bits), .baud_div_o(baud_div), .irq_o(irq)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: byte queues for each FIFO plus the sticky overrun flag.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_ovr = 1'b0;

    function automatic logic [31:0] exp_status();
        return {8'h00, 8'(rx_q.size()), 8'(tx_q.size()), 3'b000, m_ovr,
                rx_q.size() == 0, rx_q.size() == DEPTH, tx_q.size() == 0, tx_q.size() == DEPTH};
    endfunction

    function automatic logic [7:0] keep_bits(input logic [7:0] d, input int db);
        return 8'(int'(d) % (1 << (db + 5)));
    endfunction

    // Bounded bus access; returns read data and cycles to ready, then leaves one idle cycle.
    task automatic bus_xfer(input logic wr, input logic [7:0] off, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat);
        bus.daddr_i  = BASE | {24'h0, off};
        bus.dwdata_i = wd;
        bus.dwrite_i = wr;
        bus.dstrb_i  = 4'hF;
        bus.dvalid_i = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!bus.dready_o && lat < 40);
        rd = bus.drdata_o;
        if (!bus.dready_o) begin
            tests++; fails++;
            $display("FAIL bus_timeout off=%h: no ready after %0d cycles", off, lat);
        end
        bus.dvalid_i = 1'b0;
        bus.dwrite_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reg_wr(input logic [7:0] off, input logic [31:0] wd);
        logic [31:0] d;
        int l;
        bus_xfer(1'b1, off, wd, d, l);
    endtask

    task automatic reg_rd(input logic [7:0] off, output logic [31:0] rd);
        int l;
        bus_xfer(1'b0, off, 32'h0, rd, l);
    endtask

    task automatic tx_pop();
        tx_rd_en = 1'b1;
        @(posedge clk); #1;
        tx_rd_en = 1'b0;
        if (tx_q.size() > 0) tx_q.delete(0);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data  = b;
        rx_wr_en = 1'b1;
        @(posedge clk); #1;
        rx_wr_en = 1'b0;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else                     m_ovr = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        tests++; if ({bus.dready_o, bus.drdata_o, irq} !== 34'h0) begin fails++; $display("FAIL reset_bus: got rdy=%b rd=%h irq=%b required all 0", bus.dready_o, bus.drdata_o, irq); end
        tests++; if (baud_div !== BRST) begin fails++; $display("FAIL reset_baud: got %h required %h", baud_div, BRST); end
        tests++; if ({tx_empty, rx_full, data_bits, tx_en, rx_en} !== 6'b100000) begin fails++; $display("FAIL reset_flags: got %b required 100000", {tx_empty, rx_full, data_bits, tx_en, rx_en}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        reg_rd(8'h0C, d);
        tests++; if (d !== exp_status()) begin fails++; $display("FAIL reset_status: got %h required %h", d, exp_status()); end
        reg_rd(8'h08, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h required 0", d); end
    endtask

    task automatic test_ctrl();
        logic [31:0] d, v;
        int lat;
        bus_xfer(1'b1, 8'h08, 32'h33, d, lat);
        tests++; if (lat !== 1) begin fails++; $display("FAIL ctrl_latency: got %0d required 1", lat); end
        tests++; if ({tx_en, rx_en, data_bits} !== 4'b1111) begin fails++; $display("FAIL ctrl_outputs: got %b required 1111", {tx_en, rx_en, data_bits}); end
        reg_rd(8'h08, d);
        tests++; if (d !== 32'h33) begin fails++; $display("FAIL ctrl_read: got %h required 00000033", d); end
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            reg_wr(8'h08, v);
            tests++; if ({data_bits, parity_odd, parity_en, rx_en, tx_en} !== v[5:0]) begin fails++; $display("FAIL ctrl_rand_out: got %b required %b", {data_bits, parity_odd, parity_en, rx_en, tx_en}, v[5:0]); end
            reg_rd(8'h08, d);
            tests++; if (d !== (v & 32'h3F)) begin fails++; $display("FAIL ctrl_rand_read: got %h required %h", d, v & 32'h3F); end
            v = $urandom;
            reg_wr(8'h10, v);
            reg_rd(8'h10, d);
            tests++; if (d !== v || baud_div !== v) begin fails++; $display("FAIL baud_rw: got %h/%h required %h", d, baud_div, v); end
            v = $urandom;
            reg_wr(8'h1C, v);
            reg_rd(8'h1C, d);
            tests++; if (d !== (v & 32'hFFFF)) begin fails++; $display("FAIL wm_rw: got %h required %h", d, v & 32'hFFFF); end
        end
        reg_wr(8'h1C, 32'h0);
    endtask

    task automatic test_tx_fifo();
        logic [31:0] d, v;
        int lat, db;
        db = 3;
        for (int i = 0; i < DEPTH; i++) begin
            db = $urandom_range(0, 3);
            reg_wr(8'h08, {26'h0, 2'(db), 4'b0001});
            v = $urandom;
            bus_xfer(1'b1, 8'h00, v, d, lat);
            tx_q.push_back(keep_bits(v[7:0], db));
            tests++; if (lat !== 1) begin fails++; $display("FAIL tx_push_latency: got %0d required 1", lat); end
            tests++; if (tx_data !== tx_q[0]) begin fails++; $display("FAIL tx_head: got %h required %h", tx_data, tx_q[0]); end
        end
        v = $urandom;
        bus.daddr_i = BASE; bus.dwdata_i = v; bus.dwrite_i = 1'b1; bus.dvalid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.dready_o !== 1'b0) begin fails++; $display("FAIL tx_full_stall: got ready %b required 0", bus.dready_o); end
        tests++; if (tx_data !== tx_q[0]) begin fails++; $display("FAIL tx_head_full: got %h required %h", tx_data, tx_q[0]); end
        tx_rd_en = 1'b1;
        @(posedge clk); #1;
        tx_rd_en = 1'b0;
        tx_q.delete(0);
        tests++; if (bus.dready_o !== 1'b0) begin fails++; $display("FAIL tx_pop_same_cycle: got ready %b required 0", bus.dready_o); end
        @(posedge clk); #1;
        tests++; if (bus.dready_o !== 1'b1) begin fails++; $display("FAIL tx_unstall: got ready %b required 1", bus.dready_o); end
        tx_q.push_back(keep_bits(v[7:0], db));
        bus.dvalid_i = 1'b0; bus.dwrite_i = 1'b0;
        @(posedge clk); #1;
        reg_rd(8'h0C, d);
        tests++; if (d !== exp_status()) begin fails++; $display("FAIL tx_full_status: got %h required %h", d, exp_status()); end
        while (tx_q.size() > 0) begin
            tests++; if (tx_data !== tx_q[0]) begin fails++; $display("FAIL tx_drain: got %h required %h", tx_data, tx_q[0]); end
            tx_pop();
        end
        tx_pop();
        reg_rd(8'h0C, d);
        tests++; if (d !== exp_status() || tx_empty !== 1'b1) begin fails++; $display("FAIL tx_pop_empty: got %h empty=%b required %h", d, tx_empty, exp_status()); end
    endtask

    task automatic test_rx_stall();
        logic [31:0] d;
        bus.daddr_i = BASE | 32'h04; bus.dwrite_i = 1'b0; bus.dvalid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.dready_o !== 1'b0) begin fails++; $display("FAIL rx_empty_stall: got ready %b required 0", bus.dready_o); end
        rx_data = 8'hA5; rx_wr_en = 1'b1;
        @(posedge clk); #1;
        rx_wr_en = 1'b0;
        tests++; if (bus.dready_o !== 1'b0) begin fails++; $display("FAIL rx_push_edge: got ready %b required 0", bus.dready_o); end
        @(posedge clk); #1;
        tests++; if (bus.dready_o !== 1'b1 || bus.drdata_o !== 32'hA5) begin fails++; $display("FAIL rx_unstall: got ready %b data %h required 1/000000a5", bus.dready_o, bus.drdata_o); end
        bus.dvalid_i = 1'b0;
        @(posedge clk); #1;
        tests++; if (bus.drdata_o !== 32'h0) begin fails++; $display("FAIL rdata_idle: got %h required 0", bus.drdata_o); end
        reg_rd(8'h0C, d);
        tests++; if (d !== exp_status()) begin fails++; $display("FAIL rx_level_zero: got %h required %h", d, exp_status()); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        for (int i = 0; i <= DEPTH; i++) rx_push(8'($urandom));
        tests++; if (rx_full !== 1'b1) begin fails++; $display("FAIL rx_full_flag: got %b required 1", rx_full); end
        reg_rd(8'h0C, d);
        tests++; if (d !== exp_status()) begin fails++; $display("FAIL rx_overrun_status: got %h required %h", d, exp_status()); end
        reg_wr(8'h0C, 32'h10);
        m_ovr = 1'b0;
        reg_rd(8'h0C, d);
        tests++; if (d !== exp_status()) begin fails++; $display("FAIL rx_overrun_w1c: got %h required %h", d, exp_status()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  b;
        b = 8'($urandom);
        bus.daddr_i = BASE | 32'h04; bus.dwrite_i = 1'b0; bus.dvalid_i = 1'b1;
        rx_data = b; rx_wr_en = 1'b1;
        @(posedge clk); #1;
        rx_wr_en = 1'b0;
        tests++; if (bus.dready_o !== 1'b1 || bus.drdata_o !== {24'h0, rx_q[0]}) begin fails++; $display("FAIL rx_full_pushpop: got ready %b data %h required 1/%h", bus.dready_o, bus.drdata_o, {24'h0, rx_q[0]}); end
        rx_q.delete(0);
        rx_q.push_back(b);
        bus.dvalid_i = 1'b0;
        @(posedge clk); #1;
        reg_rd(8'h0C, d);
        tests++; if (d !== exp_status()) begin fails++; $display("FAIL rx_pushpop_status: got %h required %h", d, exp_status()); end
        while (rx_q.size() > 0) begin
            reg_rd(8'h04, d);
            tests++; if (d !== {24'h0, rx_q[0]}) begin fails++; $display("FAIL rx_drain: got %h required %h", d, {24'h0, rx_q[0]}); end
            rx_q.delete(0);
        end
    endtask

    task automatic test_misc();
        logic [31:0] d, s;
        int lat;
        reg_wr(8'h08, 32'h0);
        reg_wr(8'h00, 32'hFF);
        tx_q.push_back(8'h1F);
        tests++; if (tx_data !== 8'h1F) begin fails++; $display("FAIL tx_mask5: got %h required 1f", tx_data); end
        reg_rd(8'h40, d);
        tests++; if (d !== BAD) begin fails++; $display("FAIL unmapped_read: got %h required %h", d, BAD); end
        reg_rd(8'h00, d);
        tests++; if (d !== BAD) begin fails++; $display("FAIL txdata_read: got %h required %h", d, BAD); end
        reg_rd(8'(32 + 4 * $urandom_range(0, 55)), d);
        tests++; if (d !== BAD) begin fails++; $display("FAIL unmapped_rand_read: got %h required %h", d, BAD); end
        reg_rd(8'h0C, s);
        bus_xfer(1'b1, 8'h04, $urandom, d, lat);
        reg_rd(8'h0C, d);
        tests++; if (lat !== 1 || d !== s) begin fails++; $display("FAIL ro_write: got lat %0d status %h required 1/%h", lat, d, s); end
        bus.daddr_i = 32'h5000_0008; bus.dwrite_i = 1'b0; bus.dvalid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.dready_o !== 1'b0) begin fails++; $display("FAIL wrong_base: got ready %b required 0", bus.dready_o); end
        bus.dvalid_i = 1'b0;
        @(posedge clk); #1;
        tx_pop();
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int lat;
`ifdef UART_IRQ_EN
        reg_wr(8'h1C, 32'h0000_0200);
        reg_wr(8'h18, 32'h7);
        reg_wr(8'h14, 32'h2);
        reg_rd(8'h14, d);
        tests++; if (d !== 32'h2) begin fails++; $display("FAIL irq_en_read: got %h required 2", d); end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b required 0", irq); end
        rx_push(8'($urandom));
        rx_push(8'($urandom));
        repeat (2) @(posedge clk);
        #1;
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_rx_wm: got %b required 1", irq); end
        reg_rd(8'h04, d);
        tests++; if (d !== {24'h0, rx_q[0]}) begin fails++; $display("FAIL irq_rx_read: got %h required %h", d, {24'h0, rx_q[0]}); end
        rx_q.delete(0);
        reg_wr(8'h18, 32'h2);
        repeat (2) @(posedge clk);
        #1;
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_w1c: got %b required 0", irq); end
        reg_rd(8'h04, d);
        rx_q.delete(0);
        reg_wr(8'h14, 32'h0);
`else
        reg_rd(8'h14, d);
        tests++; if (d !== BAD) begin fails++; $display("FAIL irq_en_absent: got %h required %h", d, BAD); end
        reg_rd(8'h18, d);
        tests++; if (d !== BAD) begin fails++; $display("FAIL irq_stat_absent: got %h required %h", d, BAD); end
        bus_xfer(1'b1, 8'h14, 32'hFFFF_FFFF, d, lat);
        tests++; if (lat !== 1 || irq !== 1'b0) begin fails++; $display("FAIL irq_tied: got lat %0d irq %b required 1/0", lat, irq); end
`endif
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        reg_wr(8'h08, 32'h31);
        for (int i = 0; i < DEPTH; i++) reg_wr(8'h00, $urandom);
        bus.daddr_i = BASE; bus.dwdata_i = $urandom; bus.dwrite_i = 1'b1; bus.dvalid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.dvalid_i = 1'b0; bus.dwrite_i = 1'b0;
        rst_n = 1'b1;
        tx_q.delete(); rx_q.delete(); m_ovr = 1'b0;
        tests++; if (bus.dready_o !== 1'b0 || tx_empty !== 1'b1 || baud_div !== BRST || tx_en !== 1'b0) begin fails++; $display("FAIL reset_abort: got rdy %b empty %b baud %h tx_en %b", bus.dready_o, tx_empty, baud_div, tx_en); end
        @(posedge clk); #1;
        reg_rd(8'h0C, d);
        tests++; if (d !== exp_status()) begin fails++; $display("FAIL reset_abort_status: got %h required %h", d, exp_status()); end
    endtask

    initial begin
        bus.daddr_i = '0; bus.dwdata_i = '0; bus.dstrb_i = '0; bus.dwrite_i = 1'b0; bus.dvalid_i = 1'b0;
        tx_rd_en = 1'b0; rx_wr_en = 1'b0; rx_data = '0;
        test_reset();
        test_ctrl();
        test_tx_fifo();
        test_rx_stall();
        test_rx_overrun();
        test_back_to_back();
        test_misc();
        test_irq();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_ctrl_regs.md
UART_CTRL_REGS -- requirements
Module: uart_ctrl_regs

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, 32'h4000_0000: region base, matched on daddr_i[31:16].
REQ-002 The block SHALL have parameter DEPTH, 8: per-direction FIFO depth, a power of two and at least 2; level width LW = $clog2(DEPTH)+1.
REQ-003 The block SHALL have parameter BAUD_DIV_RST, 32'd0: reset value of BAUD_DIV.
REQ-004 The block SHALL have input clk, 1 bit: clock, all logic on posedge.
REQ-005 The block SHALL have input rst_n, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have bus ports daddr_i in 32, dwdata_i in 32, dstrb_i in 4 (ignored; all writes full-word), dwrite_i in 1, dvalid_i in 1, drdata_o out 32, dready_o out 1.
REQ-007 The block SHALL have TX-side ports tx_rd_en_i in 1 (pop), tx_data_o out 8 (FWFT head), tx_empty_o out 1.
REQ-008 The block SHALL have RX-side ports rx_wr_en_i in 1 (push), rx_data_i in 8, rx_full_o out 1.
REQ-009 The block SHALL have config outputs tx_en_o 1, rx_en_o 1, parity_en_o 1, parity_odd_o 1, data_bits_o 2 (00=5 .. 11=8), baud_div_o 32, and irq_o out 1.

Function
REQ-010 Hit SHALL be dvalid_i && daddr_i[31:16]==BASE_ADDR[31:16]; the register is selected by daddr_i[7:0].
REQ-011 Map SHALL be: 0x00 TXDATA W; 0x04 RXDATA R; 0x08 CTRL RW {[5:4] data_bits, [3] parity_odd, [2] parity_en, [1] rx_en, [0] tx_en}; 0x0C STATUS; 0x10 BAUD_DIV RW; 0x14 IRQ_EN RW [2:0]; 0x18 IRQ_STAT W1C [2:0]; 0x1C WM RW {[15:8] rx_wm, [7:0] tx_wm}.
REQ-012 STATUS SHALL be {[31:24] 0, [23:16] rx_level, [15:8] tx_level, [4] rx_overrun (sticky, W1C), [3] rx_empty, [2] rx_full, [1] tx_empty, [0] tx_full}; all other bits write-ignored.
REQ-013 The bus FSM SHALL have states IDLE and ACK: IDLE->ACK on a hit whose completion condition holds; ACK->IDLE unconditionally; dready_o=1 only in ACK, exactly one cycle per access; no access is accepted in ACK.
REQ-014 Completion conditions SHALL be: a TXDATA write waits while tx_full; an RXDATA read waits while rx_empty (dready_o held 0, FSM in IDLE); all others complete immediately, giving latency 1 cycle.
REQ-015 On the IDLE->ACK edge the block SHALL perform the register write / FIFO push / FIFO pop and register drdata_o; drdata_o is valid while dready_o=1 and is 0 otherwise.
REQ-016 A TXDATA push SHALL store dwdata_i[7:0] with bits above data_bits zeroed; RXDATA reads SHALL return {24'b0, head byte}.
REQ-017 Reads of unmapped or write-only offsets SHALL return 32'hDEADDEAD; writes to unmapped or read-only offsets SHALL be acked and ignored.
REQ-018 The FIFOs SHALL be circular buffers with wrapping pointers and a registered level; simultaneous push and pop SHALL leave the level unchanged, including at full and at empty for the RX FIFO.
REQ-019 tx_rd_en_i while TX is empty SHALL be ignored; rx_wr_en_i while rx_full and no same-cycle pop SHALL drop the byte and set rx_overrun.
REQ-020 Full and empty SHALL be computed from the registered level; a bus TXDATA write SHALL stall while full even if a same-cycle UART pop occurs.

Reset
REQ-021 While rst_n=0 at posedge clk, the block SHALL clear all registers and flags to 0, set BAUD_DIV to BAUD_DIV_RST, empty both FIFOs, set FSM=IDLE, and drive dready_o=0, drdata_o=0, irq_o=0.
REQ-022 Reset during a stalled access SHALL abandon it; no push or pop SHALL occur.

Configuration
REQ-023 When UART_IRQ_EN is defined, IRQ_STAT bits SHALL be set by: [0] tx_level<=tx_wm, [1] rx_level>=rx_wm (level-sampled each cycle, set wins over W1C), [2] rx_overrun rising; irq_o SHALL be a registered |(IRQ_STAT & IRQ_EN).
REQ-024 When UART_IRQ_EN is undefined, the block SHALL tie irq_o to 0, read 0x14/0x18 as 32'hDEADDEAD, and ack and ignore writes to them; WM SHALL remain.

Verification
REQ-025 Write CTRL=0x33 -> dready_o 1 cycle later; tx_en_o=1, rx_en_o=1, data_bits_o=11; read CTRL returns 0x33.
REQ-026 Nine TXDATA writes, DEPTH=8, no pops -> 9th stalls with dready_o=0; one tx_rd_en_i pulse -> 9th acks next cycle; tx_level=8.
REQ-027 RXDATA read on empty FIFO stalls; rx_wr_en_i with 0xA5 -> ack, drdata_o=0x000000A5, rx_level returns to 0.
REQ-028 Nine RX pushes, DEPTH=8 -> STATUS[4]=1, rx_level=8; write STATUS 0x10 -> bit clears; first read returns the first byte.
REQ-029 With UART_IRQ_EN: rx_wm=2, IRQ_EN=0x2, two pushes -> irq_o=1; drain one byte, W1C 0x2 -> irq_o=0.
REQ-030 data_bits=00, TXDATA write 0xFF -> tx_data_o=0x1F; read offset 0x40 -> 0xDEADDEAD.
